time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
// - Upstream of the tube scan/decode stage: keeps hours/minutes/seconds and drives display_hour/min/sec (binary 0..23/0..59/0..59).
// - Derives a 1 Hz tick from clk and counts time.
// - Two push-buttons step through a set-time FSM and increment the selected field.
// PARAMETERS
// - TICK_DIV  50_000_000  clk cycles per seconds tick; legal values >= 2.
// PORTS
// - clk           in   1  system clock; all logic on its rising edge
// - rst_n         in   1  asynchronous, active-low reset
// - btn_mode      in   1  raw mode button, level, asynchronous to clk
// - btn_inc       in   1  raw increment button, level, asynchronous to clk
// - display_hour  out  7  hours 0..23, registered
// - display_min   out  7  minutes 0..59, registered
// - display_sec   out  7  seconds 0..59, registered
// - set_mode      out  2  FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
// BEHAVIOUR
// - Reset (rst_n low, async):
//   - display_hour, display_min, display_sec = 0.
//   - set_mode = RUN; divider = 0; sync/edge registers = 0.
// - Buttons:
//   - Each button has a 2-FF synchroniser, then a rising-edge detect.
//   - The edge detect gives a 1-cycle press pulse.
//   - Latency from input rise to field/state change: 3 clk edges.
//   - A held button generates one press only; there is no debounce.
// - Divider:
//   - Counts 0..TICK_DIV-1 in RUN only.
//   - tick is asserted in the cycle where divider == TICK_DIV-1; the divider wraps to 0 on that cycle.
// - RUN, on tick:
//   - sec+1. sec 59 -> 0 and carries to min.
//   - min 59 -> 0 and carries to hour. hour 23 -> 0.
//   - All carries update on the same edge (23:59:59 -> 00:00:00 in one cycle).
// - FSM: a mode press steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
// - Entering SET_HOUR: the divider clears to 0 and holds; time is frozen.
// - inc press in SET_x: increments only the selected field, with wrap and no carry.
//   - hour 23 -> 0; min/sec 59 -> 0.
// - inc press in RUN: ignored.
// - SET_SEC -> RUN: the divider restarts from 0. First tick comes TICK_DIV cycles after the return to RUN.
// - Same-cycle presses: a mode press and an inc press in the same cycle -> mode wins; inc is dropped.
// - Same-cycle tick: a tick in the same cycle as a mode press from RUN -> the tick is dropped; time is frozen at its pre-tick value.
// - Reset mid-operation: returns to RUN at 00:00:00 immediately; a pending press is lost.
// CONFIGURATION
// - ALARM_EN defined:
//   - Adds input alarm_hour[6:0], input alarm_min[6:0] and output alarm (1 bit, reset 0).
//   - alarm is registered. It is 1 while set_mode == RUN and display_hour == alarm_hour and display_min == alarm_min, unless silenced.
//   - Silencing: an inc press while alarm = 1 sets it; alarm drops next cycle.
//   - The silence clears when the hour:min match ends.
// - ALARM_EN undefined: the alarm ports and logic are absent; everything else is identical.
// TESTING (TICK_DIV=4)
// - Reset release, no buttons, 40 clk:
//   - first tick at clk 4 gives sec=1; sec=10 after 40 clk; min=hour=0.
// - Preload 23:59:58 via SET mode, return to RUN, 8 clk:
//   - reads 23:59:59, then 00:00:00 on one edge.
// - Mode press x1, inc press x25: set_mode=1, hour=1 (wrapped at 24).
//   - min and sec unchanged; sec does not advance over 200 clk.
// - Mode and inc rise on the same clk: set_mode advances by 1; no field changes.
// - rst_n low mid-count in SET_MIN at 12:34:56, asynchronously between edges:
//   - outputs are 00:00:00 and set_mode=0 before the next edge.
// - ALARM_EN, alarm=07:00, time 06:59:59, RUN:
//   - alarm rises the cycle after the tick to 07:00:00.
//   - An inc press clears it; it stays 0 until after 07:01.

Source files
------------

// File: rtl/time_keeper.sv
// Hours/minutes/seconds clock with a two-button set-time FSM and a TICK_DIV-cycle seconds tick.
// Optional alarm compare/silence logic when ALARM_EN is defined.
module time_keeper #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
`ifdef ALARM_EN
    input  logic [6:0] alarm_hour,
    input  logic [6:0] alarm_min,
    output logic       alarm,
`endif
    output logic [6:0] display_hour,
    output logic [6:0] display_min,
    output logic [6:0] display_sec,
    output logic [1:0] set_mode
);

    localparam int DW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

    mode_t         state;
    logic [DW-1:0] div;
    logic          mode_s1, mode_s2, mode_q;
    logic          inc_s1, inc_s2, inc_q;
    logic          mode_press, inc_press, tick;

    // Buttons are asynchronous: two flops to resynchronise, a third for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            mode_q  <= 1'b0;
            inc_s1  <= 1'b0;
            inc_s2  <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            mode_s1 <= btn_mode;
            mode_s2 <= mode_s1;
            mode_q  <= mode_s2;
            inc_s1  <= btn_inc;
            inc_s2  <= inc_s1;
            inc_q   <= inc_s2;
        end
    end

    assign mode_press = mode_s2 & ~mode_q;
    assign inc_press  = inc_s2 & ~inc_q & ~mode_press;
    assign tick       = (state == RUN) && (div == DW'(TICK_DIV - 1));
    assign set_mode   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            div          <= '0;
            display_hour <= '0;
            display_min  <= '0;
            display_sec  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mode_press) begin
                        // A coincident tick is discarded so the frozen time is the pre-tick value.
                        state <= SET_HOUR;
                        div   <= '0;
                    end else if (tick) begin
                        div         <= '0;
                        display_sec <= (display_sec == 7'd59) ? 7'd0 : display_sec + 7'd1;
                        if (display_sec == 7'd59) begin
                            display_min <= (display_min == 7'd59) ? 7'd0 : display_min + 7'd1;
                            if (display_min == 7'd59)
                                display_hour <= (display_hour == 7'd23) ? 7'd0 : display_hour + 7'd1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                SET_HOUR: begin
                    div <= '0;
                    if (mode_press)
                        state <= SET_MIN;
                    else if (inc_press)
                        display_hour <= (display_hour == 7'd23) ? 7'd0 : display_hour + 7'd1;
                end
                SET_MIN: begin
                    div <= '0;
                    if (mode_press)
                        state <= SET_SEC;
                    else if (inc_press)
                        display_min <= (display_min == 7'd59) ? 7'd0 : display_min + 7'd1;
                end
                default: begin
                    div <= '0;
                    if (mode_press)
                        state <= RUN;
                    else if (inc_press)
                        display_sec <= (display_sec == 7'd59) ? 7'd0 : display_sec + 7'd1;
                end
            endcase
        end
    end

`ifdef ALARM_EN
    logic hm_match, silenced, silence_now;

    assign hm_match    = (display_hour == alarm_hour) && (display_min == alarm_min);
    assign silence_now = inc_press & alarm;

    // Silence persists for the rest of the hour:min match, then re-arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            silenced <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            silenced <= hm_match & (silenced | silence_now);
            alarm    <= hm_match & (state == RUN) & ~silenced & ~silence_now;
        end
    end
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed and randomized checks of time_keeper (TICK_DIV=4) against a seconds-of-day reference model.
module tb_time_keeper;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [6:0] display_hour, display_min, display_sec;
    logic [1:0] set_mode;
`ifdef ALARM_EN
    logic [6:0] alarm_hour = 7'd7;
    logic [6:0] alarm_min  = 7'd0;
    logic       alarm;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: time as seconds of day, mode 0..3, cycles since last tick/RUN entry.
    int       tod, md, rc;
    bit [3:0] mh, ih;
    bit       a_exp, sil;

    time_keeper #(.TICK_DIV(TD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
`ifdef ALARM_EN
        .alarm_hour(alarm_hour),
        .alarm_min(alarm_min),
        .alarm(alarm),
`endif
        .display_hour(display_hour),
        .display_min(display_min),
        .display_sec(display_sec),
        .set_mode(set_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tod = 0; md = 0; rc = 0; mh = '0; ih = '0; a_exp = 0; sil = 0;
    endtask

    task automatic model_edge();
        bit mp, ip, hm, na;
        int h, m, s;
        mh = {mh[2:0], btn_mode};
        ih = {ih[2:0], btn_inc};
        // A press acts on the third edge after the level is first sampled high.
        mp = mh[2] & ~mh[3];
        ip = ih[2] & ~ih[3] & ~mp;
`ifdef ALARM_EN
        hm  = (tod / 3600 == int'(alarm_hour)) && ((tod / 60) % 60 == int'(alarm_min));
        na  = hm && md == 0 && !sil && !(ip && a_exp);
        sil = hm && (sil || (ip && a_exp));
        a_exp = na;
`else
        hm = 0; na = 0;
`endif
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        if (md == 0) begin
            if (mp) begin
                md = 1; rc = 0;
            end else begin
                rc++;
                if (rc == TD) begin
                    rc = 0;
                    tod = (tod + 1) % 86400;
                end
            end
        end else if (mp) begin
            md = (md + 1) % 4; rc = 0;
        end else if (ip) begin
            if (md == 1) h = (h + 1) % 24;
            if (md == 2) m = (m + 1) % 60;
            if (md == 3) s = (s + 1) % 60;
            tod = h * 3600 + m * 60 + s;
        end
    endtask

    task automatic check_all();
        chk("hour", display_hour, tod / 3600);
        chk("min", display_min, (tod / 60) % 60);
        chk("sec", display_sec, tod % 60);
        chk("set_mode", set_mode, md);
`ifdef ALARM_EN
        chk("alarm", alarm, a_exp);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic press(input bit m, input bit i);
        btn_mode = m; btn_inc = i;
        step();
        btn_mode = 0; btn_inc = 0;
        step();
    endtask

    task automatic presses(input bit m, input bit i, input int n);
        for (int k = 0; k < n; k++) press(m, i);
    endtask

    // Called at posedge+1: asserts reset between edges and releases it after one edge.
    task automatic do_reset();
        btn_mode = 0; btn_inc = 0;
        #3 rst_n = 0;
        #1;
        chk("rst_hour", display_hour, 0);
        chk("rst_min", display_min, 0);
        chk("rst_sec", display_sec, 0);
        chk("rst_mode", set_mode, 0);
        @(posedge clk);
        #3 rst_n = 1;
        model_reset();
    endtask

    // Leaves the DUT in RUN with the given time, on the edge that re-enters RUN.
    task automatic set_time(input int h, input int m, input int s);
        press(1, 0); presses(0, 1, h);
        press(1, 0); presses(0, 1, m);
        press(1, 0); presses(0, 1, s);
        press(1, 0);
        step();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Free run from reset
        for (int k = 0; k < 4; k++) step();
        chk("first_tick_sec", display_sec, 1);
        for (int k = 0; k < 36; k++) step();
        chk("sec_after_40", display_sec, 10);
        chk("min_after_40", display_min, 0);

        // Full-carry rollover
        do_reset();
        set_time(23, 59, 58);
        chk("preload_mode", set_mode, 0);
        for (int k = 0; k < 3; k++) step();
        chk("preload_sec", display_sec, 58);
        step();
        chk("pre_wrap_hour", display_hour, 23);
        chk("pre_wrap_sec", display_sec, 59);
        for (int k = 0; k < 4; k++) step();
        chk("wrap_hour", display_hour, 0);
        chk("wrap_min", display_min, 0);
        chk("wrap_sec", display_sec, 0);

        // Hour increment wraps at 24, time frozen in SET
        do_reset();
        press(1, 0);
        presses(0, 1, 25);
        step();
        for (int k = 0; k < 200; k++) step();
        chk("set_hour_mode", set_mode, 1);
        chk("set_hour_val", display_hour, 1);
        chk("set_hour_min", display_min, 0);
        chk("set_hour_sec", display_sec, 0);

        // Mode and inc together: mode wins
        press(1, 1);
        step();
        chk("both_mode", set_mode, 2);
        chk("both_hour", display_hour, 1);
        chk("both_min", display_min, 0);

        // Mode press coinciding with the first tick drops the tick
        do_reset();
        step();
        press(1, 0);
        step();
        chk("tick_drop_mode", set_mode, 1);
        chk("tick_drop_sec", display_sec, 0);
        for (int k = 0; k < 10; k++) step();
        chk("tick_drop_frozen", display_sec, 0);

        // Asynchronous reset while in SET_MIN at 12:34:56
        do_reset();
        set_time(12, 34, 56);
        press(1, 0); press(1, 0);
        step();
        chk("pre_rst_mode", set_mode, 2);
        chk("pre_rst_hour", display_hour, 12);
        chk("pre_rst_min", display_min, 34);
        chk("pre_rst_sec", display_sec, 56);
        do_reset();

`ifdef ALARM_EN
        // Alarm at 07:00: rises after the tick, silenced by inc
        set_time(6, 59, 59);
        for (int k = 0; k < 4; k++) step();
        chk("alarm_time_min", display_min, 0);
        chk("alarm_not_yet", alarm, 0);
        step();
        chk("alarm_rise", alarm, 1);
        press(0, 1);
        step();
        chk("alarm_silenced", alarm, 0);
        for (int k = 0; k < 250; k++) step();
        chk("alarm_after_0701_min", display_min, 1);
        chk("alarm_after_0701", alarm, 0);
`endif

        // Random button activity against the model
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            btn_mode = ($urandom_range(0, 9) == 0);
            btn_inc  = ($urandom_range(0, 2) == 0);
            step();
        end
        btn_mode = 0; btn_inc = 0;
        for (int k = 0; k < 10; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
